// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in/serial-out transmitter.
// Frame = start bit (0), WIDTH data bits LSB first, optional even parity, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks. tx is registered, so nothing from
// in_valid/in_data reaches tx without passing through a flop.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle (tx=1), ready to accept a word
// S_START  | driving the start bit (tx=0)
// S_DATA   | driving shift register bit 0, LSB first
// S_PARITY | driving the latched even-parity bit
// S_STOP   | driving the stop bit (tx=1)
module piso_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [IW-1:0]    idx, idx_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic             par, par_next;
  logic             tx_next;
  logic             done_next;

  logic bit_end;
  assign bit_end = (cnt == CNT_LAST);

  // State register plus datapath flops; rst wins over any acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shift <= shift_next;
      par   <= par_next;
      tx    <= tx_next;
      done  <= done_next;
    end
  end

  // Next-state and datapath updates; tx_next is the line level for the next state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shift_next = shift;
    par_next   = par;
    done_next  = 1'b0;
    tx_next    = 1'b1;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          shift_next = in_data;
          par_next   = ^in_data;
          cnt_next   = '0;
          idx_next   = '0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = S_DATA;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_next = idx + IDX_ONE;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = S_STOP;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_next   = '0;
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_next;
      default:  tx_next = 1'b1;
    endcase
  end

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: a cycle-position model predicts every output of two
// instances (defaults, and WIDTH=4/CLKS_PER_BIT=1/no parity) on every cycle,
// and directed frames are pinned against hand-computed bit sequences.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, in_valid0, in_ready0, tx0, busy0, done0;
  logic [7:0] in_data0;
  logic       rst1, in_valid1, in_ready1, tx1, busy1, done1;
  logic [3:0] in_data1;

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .done(done0));

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .done(done1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t = position of the coming cycle within the frame (1..F), 0 = idle.
  int         m_t[2];
  logic [7:0] m_w[2];
  logic       m_done[2];

  initial begin
    m_t[0] = 0; m_t[1] = 0;
    m_w[0] = 8'h00; m_w[1] = 8'h00;
    m_done[0] = 1'b0; m_done[1] = 1'b0;
  end

  task automatic step(input int k, input logic r, input logic v, input logic [7:0] d, input int f);
    m_done[k] = (!r && m_t[k] == f);
    if (r) m_t[k] = 0;
    else if (m_t[k] == 0) begin
      if (v) begin
        m_w[k] = d;
        m_t[k] = 1;
      end
    end else if (m_t[k] == f) m_t[k] = 0;
    else m_t[k] = m_t[k] + 1;
  endtask

  function automatic logic exp_tx(input int t, input logic [7:0] w, input int wd, input int c, input int p);
    int b;
    if (t == 0) return 1'b1;
    b = (t - 1) / c;
    if (b == 0) return 1'b0;
    if (b <= wd) return w[b-1];
    if (p != 0 && b == wd + 1) return ^w;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    step(0, rst0, in_valid0, in_data0, 44);
    step(1, rst1, in_valid1, {4'b0000, in_data1}, 6);
  end

  always @(negedge clk) begin
    chk("m0_tx",    tx0,       exp_tx(m_t[0], m_w[0], 8, 4, 1));
    chk("m0_busy",  busy0,     m_t[0] != 0);
    chk("m0_ready", in_ready0, m_t[0] == 0);
    chk("m0_done",  done0,     m_done[0]);
    chk("m1_tx",    tx1,       exp_tx(m_t[1], m_w[1], 4, 1, 0));
    chk("m1_busy",  busy1,     m_t[1] != 0);
    chk("m1_ready", in_ready1, m_t[1] == 0);
    chk("m1_done",  done1,     m_done[1]);
  end

  logic tr[0:63], dn[0:63], bs[0:63], rd[0:63];

  task automatic start0(input logic [7:0] d);
    @(negedge clk);
    in_data0  = d;
    in_valid0 = 1'b1;
    @(posedge clk);
  endtask

  // Record cycles 1..n after the accepting edge; optionally drop valid / change data.
  task automatic capture(input int n, input int drop_i, input int chg_i, input logic [7:0] chg_d);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr[i] = tx0; dn[i] = done0; bs[i] = busy0; rd[i] = in_ready0;
      if (i == drop_i) in_valid0 = 1'b0;
      if (i == chg_i) in_data0 = chg_d;
    end
  endtask

  // e[0]=start, e[8:1]=data LSB first, e[9]=parity, e[10]=stop; 4 cycles per slot.
  task automatic check_slots(input string name, input logic [10:0] e);
    for (int s = 0; s <= 10; s++)
      for (int j = 0; j < 4; j++)
        chk(name, tr[1 + 4*s + j], e[s]);
  endtask

  initial begin
    rst0 = 1'b1; in_valid0 = 1'b0; in_data0 = 8'h00;
    rst1 = 1'b1; in_valid1 = 1'b0; in_data1 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx0, 1'b1);
    chk("rst_ready", in_ready0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5: 1,0,1,0,0,1,0,1 then parity 0
    start0(8'hA5);
    capture(46, 1, 0, 8'h00);
    check_slots("a5_bits", {1'b1, 1'b0, 8'hA5, 1'b0});
    chk("a5_busy1", bs[1], 1'b1);
    chk("a5_busy44", bs[44], 1'b1);
    chk("a5_busy45", bs[45], 1'b0);
    chk("a5_done44", dn[44], 1'b0);
    chk("a5_done45", dn[45], 1'b1);
    chk("a5_done46", dn[46], 1'b0);
    repeat (3) @(negedge clk);

    // 0x07 with in_data changed to 0xFF right after acceptance; parity 1
    start0(8'h07);
    capture(46, 1, 1, 8'hFF);
    check_slots("07_bits", {1'b1, 1'b1, 8'h07, 1'b0});
    chk("07_done45", dn[45], 1'b1);
    repeat (3) @(negedge clk);

    // Back-to-back 0x3C then 0xC3 with in_valid held
    start0(8'h3C);
    capture(47, 46, 1, 8'hC3);
    check_slots("3c_bits", {1'b1, 1'b0, 8'h3C, 1'b0});
    chk("b2b_done45", dn[45], 1'b1);
    chk("b2b_ready45", rd[45], 1'b1);
    chk("b2b_idle45", tr[45], 1'b1);
    chk("b2b_start46", tr[46], 1'b0);
    chk("b2b_busy46", bs[46], 1'b1);
    chk("b2b_start47", tr[47], 1'b0);
    repeat (48) @(negedge clk);

    // Reset during data bit 3 of 0x55 (cycles 17..20)
    start0(8'h55);
    capture(18, 1, 0, 8'h00);
    chk("55_bit3", tr[18], 1'b0);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("mid_rst_tx", tx0, 1'b1);
    chk("mid_rst_ready", in_ready0, 1'b1);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_done", done0, 1'b0);
    repeat (3) @(negedge clk);
    start0(8'h81);
    capture(46, 1, 0, 8'h00);
    check_slots("81_bits", {1'b1, 1'b0, 8'h81, 1'b0});
    chk("81_done45", dn[45], 1'b1);
    repeat (3) @(negedge clk);

    // rst and in_valid together: word must not be accepted
    @(negedge clk);
    rst0 = 1'b1; in_valid0 = 1'b1; in_data0 = 8'hFF;
    @(negedge clk);
    rst0 = 1'b0; in_valid0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rstv_tx", tx0, 1'b1);
      chk("rstv_busy", busy0, 1'b0);
    end

    // WIDTH=4, CLKS_PER_BIT=1, no parity, 0xB: 0,1,1,0,1,1 then done
    @(negedge clk);
    in_data1 = 4'hB; in_valid1 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      tr[i] = tx1; dn[i] = done1;
      if (i == 1) in_valid1 = 1'b0;
    end
    chk("b_tx1", tr[1], 1'b0);
    chk("b_tx2", tr[2], 1'b1);
    chk("b_tx3", tr[3], 1'b1);
    chk("b_tx4", tr[4], 1'b0);
    chk("b_tx5", tr[5], 1'b1);
    chk("b_tx6", tr[6], 1'b1);
    chk("b_done6", dn[6], 1'b0);
    chk("b_done7", dn[7], 1'b1);
    chk("b_tx7", tr[7], 1'b1);
    chk("b_done8", dn[8], 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
